// File: rtl/serial_r_pkg.sv
// serial_r_pkg -- shared definitions for the UART receive path.
//
// Contents:
//   state_e              receiver FSM state encoding
//   CLK_PER_BIT_DEFAULT  default clk cycles per UART bit (50 MHz / 500 kbaud)
//   DATA_BITS            payload bits per 8N1 frame
//   RX_IDLE_LEVEL        idle (marking) level of the UART line
package serial_r_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int unsigned CLK_PER_BIT_DEFAULT = 100;
  localparam int unsigned DATA_BITS           = 8;
  localparam logic        RX_IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/serial_r_sync.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
//
// Ports:
//   clk      in   sampling clock
//   rst_n_i  in   asynchronous active-low reset; both flops load RESET_VAL
//   d_i      in   asynchronous input
//   q_o      out  synchronized output, two clk cycles behind d_i
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_r.sv
// serial_r -- 8N1 UART receiver with mid-bit sampling.
//
// Parameters:
//   CLK_PER_BIT  clk cycles per UART bit (16..65535)
//
// Ports:
//   clk        in   sole clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   rx         in   asynchronous UART line, idle high
//   data       out  last correctly framed byte (LSB first on the line)
//   new_data   out  one-cycle pulse when data is updated
//   frame_err  out  one-cycle pulse when the stop bit was sampled low
//   busy       out  high whenever the receiver is not idle
module serial_r
  import serial_r_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 new_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);

  // The start bit is re-checked half a bit in so that every later sample
  // lands in the middle of its bit cell.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 new_data_q, new_data_d;
  logic                 frame_err_q, frame_err_d;

  sync_2ff #(
    .RESET_VAL (RX_IDLE_LEVEL)
  ) u_sync (
    .clk     (clk),
    .rst_n_i (rst),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end

      // A line that is high again at mid-start is treated as a glitch.
      ST_START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      // The bit counter is cleared rather than incremented past the last
      // bit so it never wraps.
      ST_DATA: begin
        if (cyc_q == FULL_LAST) begin
          shift_d[bit_q] = rx_s;
          cyc_d          = '0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      // Leaving STOP at mid-stop-bit puts the FSM back in IDLE half a bit
      // before a back-to-back start edge can reach rx_s.
      ST_STOP: begin
        if (cyc_q == FULL_LAST) begin
          cyc_d = '0;
          if (rx_s) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_RECOVER;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      // Waiting for the line to return high keeps a held break from being
      // decoded as a stream of 0x00 frames with framing errors.
      ST_RECOVER: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign new_data  = new_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_r.sv
// tb_serial_r -- self-checking bench for serial_r at 16 clk cycles per bit.
// Frames are driven bit-serially on rx; expected bytes go into a scoreboard
// queue and are popped by a monitor whenever new_data pulses.
module tb_serial_r;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       new_data;
  logic       frame_err;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  int         nd_cnt   = 0;
  int         fe_cnt   = 0;
  int         exp_nd   = 0;
  int         exp_fe   = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] byte_val;
    logic       stop_bit;
    int         low_hold;
    int         idle_after;
    logic       exp_new;
  } vec_t;

  vec_t vecs[6];

  serial_r #(
    .CLK_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .new_data  (new_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Hold rx at a level for n cycles; returns 1 time unit after a posedge.
  task automatic driveLevel(input logic v, input int n);
    rx = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop, input int low_hold);
    driveLevel(1'b0, CPB);
    for (int i = 0; i < 8; i++) driveLevel(b[i], CPB);
    driveLevel(stop, CPB);
    if (low_hold > 0) driveLevel(1'b0, low_hold);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("busy returns low", {31'd0, busy}, 32'd0);
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, " new_data count"}, nd_cnt, exp_nd);
    checkOutput({tag, " frame_err count"}, fe_cnt, exp_fe);
    checkOutput({tag, " data held"}, {24'd0, data}, {24'd0, last_good});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (new_data && frame_err) begin
        checkOutput("new_data and frame_err exclusive", 32'd1, 32'd0);
      end
      if (new_data) begin
        nd_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected new_data", {24'd0, data}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("received byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;

    vecs[0] = '{8'h55, 1'b0, 40, 20, 1'b0};
    vecs[1] = '{8'h3C, 1'b1,  0, 20, 1'b1};
    vecs[2] = '{8'h00, 1'b1,  0,  0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1,  0,  0, 1'b1};
    vecs[4] = '{8'h81, 1'b1,  0, 20, 1'b1};
    vecs[5] = '{8'hA5, 1'b1,  0, 20, 1'b1};

    // Reset state
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset data", {24'd0, data}, 32'd0);
    checkOutput("reset new_data", {31'd0, new_data}, 32'd0);
    checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    driveLevel(1'b1, 5);

    // 0xAA with latency measured from the rx falling edge
    exp_q.push_back(8'hAA);
    exp_nd++;
    last_good = 8'hAA;
    lat  = -1;
    seen = 1'b0;
    fork
      applyStimulus(8'hAA, 1'b1, 0);
      begin
        for (int c = 1; c <= 300 && !seen; c++) begin
          @(posedge clk);
          #1;
          if (new_data) begin
            lat  = c;
            seen = 1'b1;
          end
        end
      end
    join
    checkRange("0xAA latency", lat, 154, 156);
    driveLevel(1'b1, 20);
    waitIdle();
    checkCounts("0xAA");

    // Table: framing error with held break, recovery, back-to-back frames
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_new) begin
        exp_q.push_back(vecs[v].byte_val);
        exp_nd++;
        last_good = vecs[v].byte_val;
      end else begin
        exp_fe++;
      end
      applyStimulus(vecs[v].byte_val, vecs[v].stop_bit, vecs[v].low_hold);
      driveLevel(1'b1, vecs[v].idle_after);
      if (vecs[v].idle_after > 0) begin
        waitIdle();
        checkCounts($sformatf("vector %0d", v));
      end
    end

    // False start: 5-cycle low glitch
    driveLevel(1'b0, 5);
    checkOutput("glitch busy high", {31'd0, busy}, 32'd1);
    driveLevel(1'b1, 30);
    checkOutput("glitch busy low", {31'd0, busy}, 32'd0);
    checkCounts("glitch");

    // Reset during bit 4 of 0xF0, then 0x0F
    fork
      applyStimulus(8'hF0, 1'b1, 0);
      begin
        repeat (5 * CPB + 8) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("mid-frame reset data", {24'd0, data}, 32'd0);
        checkOutput("mid-frame reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
      end
    join
    last_good = 8'h00;
    driveLevel(1'b1, 20);
    waitIdle();
    checkCounts("after reset abort");

    exp_q.push_back(8'h0F);
    exp_nd++;
    last_good = 8'h0F;
    applyStimulus(8'h0F, 1'b1, 0);
    driveLevel(1'b1, 20);
    waitIdle();
    checkCounts("0x0F after reset");

    checkOutput("scoreboard drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
